// File: rtl/noc_switch_alloc.sv
// Switch allocator for a 5-port router: per-output round-robin arbitration gated by downstream credits,
// with registered crossbar controls, queue pops and output valid strobes (one-cycle latency).
module noc_switch_alloc #(
  parameter int CREDITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  req_valid_i,
  input  logic [14:0] req_dir_i,
  input  logic [4:0]  credit_ret_i,
  output logic        grant_access_north_o,
  output logic        grant_access_south_o,
  output logic        grant_access_east_o,
  output logic        grant_access_west_o,
  output logic        grant_access_local_o,
  output logic [2:0]  address_route_n_o,
  output logic [2:0]  address_route_s_o,
  output logic [2:0]  address_route_e_o,
  output logic [2:0]  address_route_w_o,
  output logic [2:0]  address_route_l_o,
  output logic [4:0]  pop_o,
  output logic [4:0]  out_valid_o,
  output logic        bad_dir_o
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [2:0]    dir      [5];
  logic [4:0]    elig;
  logic [CW-1:0] credit_q [5];
  logic [CW-1:0] credit_d [5];
  logic [2:0]    rr_q     [5];
  logic [2:0]    rr_d     [5];
  logic [2:0]    route_q  [5];
  logic [2:0]    route_d  [5];
  logic [4:0]    gnt_q, gnt_d;
  logic [4:0]    ov_q, ov_d;
  logic          bad_q, bad_d;
  logic          found;
  logic          granted;
  logic [2:0]    win;
  int            idx;

  always_comb begin
    bad_d   = 1'b0;
    gnt_d   = '0;
    ov_d    = '0;
    elig    = '0;
    found   = 1'b0;
    granted = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 0; i < 5; i++) begin
      dir[i]     = req_dir_i[3*i +: 3];
      route_d[i] = 3'd0;
      // last cycle's pop masks the input until its queue head has advanced
      elig[i] = req_valid_i[i] && (dir[i] <= 3'd4) && !gnt_q[i];
      if (req_valid_i[i] && (dir[i] > 3'd4)) bad_d = 1'b1;
    end
    for (int o = 0; o < 5; o++) begin
      rr_d[o]     = rr_q[o];
      credit_d[o] = credit_q[o];
      found       = 1'b0;
      win         = '0;
      for (int k = 0; k < 5; k++) begin
        idx = int'(rr_q[o]) + k;
        if (idx >= 5) idx = idx - 5;
        if (!found && elig[idx] && (dir[idx] == 3'(o))) begin
          found = 1'b1;
          win   = 3'(idx);
        end
      end
      granted = found && (credit_q[o] != '0);
      if (granted) begin
        gnt_d[win]   = 1'b1;
        route_d[win] = 3'(o);
        ov_d[o]      = 1'b1;
        rr_d[o]      = (win == 3'd4) ? 3'd0 : win + 3'd1;
      end
      // simultaneous grant and return cancel; returns saturate at full depth
      if (granted && !credit_ret_i[o])
        credit_d[o] = credit_q[o] - 1'b1;
      else if (!granted && credit_ret_i[o] && (credit_q[o] < CW'(CREDITS)))
        credit_d[o] = credit_q[o] + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      gnt_q <= '0;
      ov_q  <= '0;
      bad_q <= 1'b0;
      for (int o = 0; o < 5; o++) begin
        credit_q[o] <= CW'(CREDITS);
        rr_q[o]     <= '0;
        route_q[o]  <= '0;
      end
    end else begin
      gnt_q <= gnt_d;
      ov_q  <= ov_d;
      bad_q <= bad_d;
      for (int o = 0; o < 5; o++) begin
        credit_q[o] <= credit_d[o];
        rr_q[o]     <= rr_d[o];
        route_q[o]  <= route_d[o];
      end
    end
  end

  assign grant_access_north_o = gnt_q[0];
  assign grant_access_south_o = gnt_q[1];
  assign grant_access_east_o  = gnt_q[2];
  assign grant_access_west_o  = gnt_q[3];
  assign grant_access_local_o = gnt_q[4];
  assign address_route_n_o    = route_q[0];
  assign address_route_s_o    = route_q[1];
  assign address_route_e_o    = route_q[2];
  assign address_route_w_o    = route_q[3];
  assign address_route_l_o    = route_q[4];
  assign pop_o                = gnt_q;
  assign out_valid_o          = ov_q;
  assign bad_dir_o            = bad_q;

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed bench for noc_switch_alloc: reset, single grant, round-robin, credit gating, saturation, bad dir.
module tb_noc_switch_alloc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_valid;
  logic [14:0] req_dir;
  logic [4:0]  credit_ret;
  logic        g_n, g_s, g_e, g_w, g_l;
  logic [2:0]  r_n, r_s, r_e, r_w, r_l;
  logic [4:0]  pop, out_valid;
  logic        bad_dir;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  noc_switch_alloc #(.CREDITS(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_dir_i(req_dir),
    .credit_ret_i(credit_ret),
    .grant_access_north_o(g_n), .grant_access_south_o(g_s), .grant_access_east_o(g_e),
    .grant_access_west_o(g_w), .grant_access_local_o(g_l),
    .address_route_n_o(r_n), .address_route_s_o(r_s), .address_route_e_o(r_e),
    .address_route_w_o(r_w), .address_route_l_o(r_l),
    .pop_o(pop), .out_valid_o(out_valid), .bad_dir_o(bad_dir)
  );

  function automatic logic [14:0] dirs(input logic [2:0] n, s, e, w, l);
    return {l, w, e, s, n};
  endfunction

  // {grants(L..N), routes(L..N), pop, out_valid, bad_dir}
  function automatic logic [30:0] snap();
    return {g_l, g_w, g_e, g_s, g_n, r_l, r_w, r_e, r_s, r_n, pop, out_valid, bad_dir};
  endfunction

  function automatic logic [30:0] mk(input logic [4:0] g, input logic [14:0] r,
                                     input logic [4:0] v, input logic b);
    return {g, r, g, v, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_dir = '0; credit_ret = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [30:0] exp_v;
    rst_n = 1'b0; req_valid = 5'h1F; req_dir = '0; credit_ret = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (snap() !== 31'd0) begin
        bad++; $display("FAIL reset_hold[%0d] got=%h want=%h", c, snap(), 31'd0);
      end
    end
    rst_n = 1'b1;
    step();
    exp_v = mk(5'b00001, 15'd0, 5'b00001, 1'b0);
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL reset_first_grant got=%h want=%h", snap(), exp_v);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [30:0] exp_v;
    do_reset();
    req_valid = 5'b00001; req_dir = dirs(3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
    step();
    req_valid = '0;
    exp_v = mk(5'b00001, dirs(3'd2, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00100, 1'b0);
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL single_grant got=%h want=%h", snap(), exp_v);
    end
    step();
    total++;
    if (snap() !== 31'd0) begin
      bad++; $display("FAIL single_idle got=%h want=%h", snap(), 31'd0);
    end
  endtask

  task automatic test_round_robin();
    int wins [6] = '{0, 1, 3, 0, 1, 3};
    logic [30:0] exp_v;
    do_reset();
    req_valid = 5'b01011; req_dir = dirs(3'd4, 3'd4, 3'd0, 3'd4, 3'd0);
    credit_ret = 5'b10000;
    for (int c = 0; c < 6; c++) begin
      step();
      exp_v = mk(5'(1 << wins[c]), 15'(15'd4 << (3 * wins[c])), 5'b10000, 1'b0);
      total++;
      if (snap() !== exp_v) begin
        bad++; $display("FAIL rr_local[%0d] got=%h want=%h", c, snap(), exp_v);
      end
    end
    req_valid = '0; credit_ret = '0;
  endtask

  task automatic test_credit_stall();
    int n = 0;
    do_reset();
    req_valid = 5'b00001; req_dir = dirs(3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
    for (int c = 0; c < 12; c++) begin
      step();
      if (pop[0] && out_valid[2]) n++;
    end
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL credit_stall_grants got=%0d want=%0d", n, 4);
    end
    credit_ret = 5'b00100;
    n = 0;
    step();
    if (pop[0]) n++;
    credit_ret = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (pop[0] && out_valid[2]) n++;
    end
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL credit_return_grants got=%0d want=%0d", n, 1);
    end
    req_valid = '0;
  endtask

  task automatic test_credit_saturate();
    int n = 0;
    do_reset();
    credit_ret = 5'b00100;
    repeat (3) step();
    credit_ret = '0;
    req_valid = 5'b00001; req_dir = dirs(3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
    for (int c = 0; c < 12; c++) begin
      step();
      if (pop[0]) n++;
    end
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL credit_saturate_grants got=%0d want=%0d", n, 4);
    end
    req_valid = '0;
  endtask

  task automatic test_credit_both();
    logic [30:0] exp_v;
    do_reset();
    req_valid = 5'b00001; req_dir = dirs(3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
    exp_v = mk(5'b00001, dirs(3'd2, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00100, 1'b0);
    repeat (6) step();
    credit_ret = 5'b00100;
    step();
    credit_ret = '0;
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL both_grant_at_one got=%h want=%h", snap(), exp_v);
    end
    repeat (2) step();
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL both_credit_kept got=%h want=%h", snap(), exp_v);
    end
    repeat (2) step();
    total++;
    if (pop !== 5'b00000) begin
      bad++; $display("FAIL both_then_empty got=%b want=%b", pop, 5'b00000);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [30:0] exp_v;
    do_reset();
    req_valid = 5'h1F; req_dir = dirs(3'd1, 3'd0, 3'd2, 3'd4, 3'd3);
    exp_v = mk(5'h1F, dirs(3'd1, 3'd0, 3'd2, 3'd4, 3'd3), 5'h1F, 1'b0);
    step();
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL parallel_all got=%h want=%h", snap(), exp_v);
    end
    step();
    total++;
    if (snap() !== 31'd0) begin
      bad++; $display("FAIL parallel_masked got=%h want=%h", snap(), 31'd0);
    end
    step();
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL parallel_again got=%h want=%h", snap(), exp_v);
    end
    req_valid = '0;
  endtask

  task automatic test_bad_dir();
    logic [30:0] exp_v;
    do_reset();
    req_valid = 5'b00110; req_dir = dirs(3'd0, 3'd0, 3'd6, 3'd0, 3'd0);
    step();
    exp_v = mk(5'b00010, 15'd0, 5'b00001, 1'b1);
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL bad_dir_first got=%h want=%h", snap(), exp_v);
    end
    step();
    exp_v = mk(5'b00000, 15'd0, 5'b00000, 1'b1);
    total++;
    if (snap() !== exp_v) begin
      bad++; $display("FAIL bad_dir_persist got=%h want=%h", snap(), exp_v);
    end
    req_valid = '0;
    step();
    total++;
    if (snap() !== 31'd0) begin
      bad++; $display("FAIL bad_dir_clear got=%h want=%h", snap(), 31'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_dir = '0; credit_ret = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_credit_saturate();
    test_credit_both();
    test_back_to_back();
    test_bad_dir();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
